flag_generator: RTL and testbench
=================================

FLAG_GENERATOR -- requirements
Module: flag_generator

Interface
REQ-001 Module SHALL expose ports as listed (name  direction  width  meaning).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a compare of op_a/op_b; sampled only in IDLE or DONE.
REQ-005 op_a  input  32  minuend.
REQ-006 op_b  input  32  subtrahend.
REQ-007 busy  output  1  high while a compare is in progress.
REQ-008 flags_valid  output  1  one-cycle pulse; zf/sf/vf/cf/diff are new this cycle.
REQ-009 diff  output  32  op_a - op_b (mod 2^32).
REQ-010 zf  output  1  zero flag: diff == 0.
REQ-011 sf  output  1  sign flag: diff[31].
REQ-012 vf  output  1  signed overflow of op_a - op_b.
REQ-013 cf  output  1  carry-out of op_a + ~op_b + 1; 1 means op_a >= op_b unsigned.

Function
REQ-014 Flags SHALL use the encoding consumed by the branch decision logic: BEQ=zf, BNE=~zf, BLT=(sf!=vf), BGE=(sf==vf), BLTU=~cf, BGEU=cf.
REQ-015 FSM SHALL have states IDLE, CALC, DONE.
REQ-016 IDLE: on start=1, latch op_a, op_b, clear byte counter to 0, set carry to 1, go to CALC; else stay.
REQ-017 CALC: each cycle add byte k of op_a, ~op_b and carry; store 8-bit sum into diff[8k+7:8k], update carry, increment k.
REQ-018 Byte order SHALL be LSB first (k = 0,1,2,3); 2-bit counter, no wrap beyond 3.
REQ-019 After the k=3 cycle, FSM SHALL go to DONE, having registered zf, sf, vf, cf from the completed diff and final carry.
REQ-020 vf SHALL equal (op_a[31] != op_b[31]) AND (diff[31] != op_a[31]) using latched operands.
REQ-021 Latency: start sampled at edge N -> CALC at edges N+1..N+4 -> flags_valid=1 in the cycle after edge N+4 (DONE).
REQ-022 busy SHALL be 1 exactly while FSM is in CALC (4 cycles).
REQ-023 flags_valid SHALL be 1 exactly while FSM is in DONE (1 cycle); DONE goes to IDLE, or to CALC if start=1 (back-to-back, new operands latched).
REQ-024 start while in CALC SHALL be ignored; operands changing during CALC SHALL not affect the result.
REQ-025 diff, zf, sf, vf, cf SHALL hold their last values from DONE until the next DONE; partial diff bytes SHALL NOT be visible before flag update (write to internal accumulator, copy at completion).

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, busy=0, flags_valid=0, diff=0, zf=0, sf=0, vf=0, cf=0, counter=0, carry=0.
REQ-027 Reset in CALC or DONE SHALL abandon the compare; no flags_valid pulse for it.
REQ-028 Reset SHALL take priority over start in the same cycle.

Verification
REQ-029 op_a=5, op_b=5, start -> 5 cycles later flags_valid=1, diff=0, zf=1, sf=0, vf=0, cf=1.
REQ-030 op_a=1, op_b=2 -> diff=0xFFFFFFFF, zf=0, sf=1, vf=0, cf=0 (BLT and BLTU true).
REQ-031 op_a=0x80000000, op_b=1 -> diff=0x7FFFFFFF, sf=0, vf=1, cf=1 (BLT true, BGEU true); op_a=0x7FFFFFFF, op_b=0xFFFFFFFF -> diff=0x80000000, sf=1, vf=1, cf=0.
REQ-032 start, then new start and changed operands on 2nd CALC cycle -> ignored; single flags_valid pulse with first-operand result; busy high 4 cycles.
REQ-033 start, rst_n=0 on 3rd CALC cycle -> next cycle busy=0, all flags 0, no flags_valid; fresh start afterwards completes normally.
REQ-034 start held high in DONE with op_a=3, op_b=7 -> no IDLE cycle; second flags_valid exactly 5 cycles after the first, diff=0xFFFFFFFC, cf=0.

Source files
------------

// File: rtl/flag_generator.sv
// flag_generator: byte-serial compare of two 32-bit operands.
// Computes diff = op_a - op_b as op_a + ~op_b + 1, one byte per cycle,
// LSB first. Branch flags are produced from the completed difference:
//   BEQ=zf  BNE=~zf  BLT=(sf!=vf)  BGE=(sf==vf)  BLTU=~cf  BGEU=cf
//
// Ports
//   clk          clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   start        request a compare; sampled only in IDLE or DONE
//   op_a, op_b   minuend / subtrahend, latched when start is accepted
//   busy         high for the 4 byte-step cycles
//   flags_valid  one-cycle pulse when diff/zf/sf/vf/cf are updated
//   diff         op_a - op_b (mod 2^32), held until the next update
//   zf/sf/vf/cf  zero / sign / signed-overflow / carry (1 = a >= b unsigned)
module flag_generator (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        flags_valid,
  output logic [31:0] diff,
  output logic        zf,
  output logic        sf,
  output logic        vf,
  output logic        cf
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [31:0] acc_q;     // partial difference, hidden until completion
  logic [1:0]  k_q;       // byte index
  logic        carry_q;

  logic [7:0]  a_byte, b_byte;
  logic [8:0]  sum9;
  logic [31:0] diff_full;
  logic        accept;

  // One byte step of a + ~b + carry.
  always_comb begin
    a_byte    = a_q[{k_q, 3'b000} +: 8];
    b_byte    = b_q[{k_q, 3'b000} +: 8];
    sum9      = {1'b0, a_byte} + {1'b0, ~b_byte} + {8'b0, carry_q};
    // Only meaningful on the k=3 step: top byte comes straight from sum9.
    diff_full = {sum9[7:0], acc_q[23:0]};
  end

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (k_q == 2'd3) state_d = DONE;
      DONE:    state_d = start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      diff    <= '0;
      zf      <= 1'b0;
      sf      <= 1'b0;
      vf      <= 1'b0;
      cf      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= op_a;
        b_q     <= op_b;
        k_q     <= '0;
        carry_q <= 1'b1;  // +1 of the two's-complement negate
      end else if (state_q == CALC) begin
        acc_q[{k_q, 3'b000} +: 8] <= sum9[7:0];
        carry_q <= sum9[8];
        if (k_q == 2'd3) begin
          // Publish everything at once so partial bytes never leak out.
          diff <= diff_full;
          zf   <= (diff_full == 32'd0);
          sf   <= sum9[7];
          cf   <= sum9[8];
          vf   <= (a_q[31] != b_q[31]) && (sum9[7] != a_q[31]);
        end else begin
          k_q <= k_q + 2'd1;
        end
      end
    end
  end

  assign busy        = (state_q == CALC);
  assign flags_valid = (state_q == DONE);

endmodule

// File: tb/tb_flag_generator.sv
module tb_flag_generator;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] op_a, op_b;
  logic        busy, flags_valid, zf, sf, vf, cf;
  logic [31:0] diff;

  flag_generator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .flags_valid(flags_valid), .diff(diff),
    .zf(zf), .sf(sf), .vf(vf), .cf(cf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] diff;
    logic        zf, sf, vf, cf;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [35:0] last_out = '0;  // {diff, zf, sf, vf, cf} last published

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Reference: subtraction and comparisons from their arithmetic meaning.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int at);
    exp_t e;
    e.diff = a - b;
    e.zf   = (a == b);
    e.sf   = e.diff[31];
    e.cf   = (a >= b);
    // Signed less-than is sf^vf, so vf is whatever makes that hold.
    e.vf   = ($signed(a) < $signed(b)) ^ e.sf;
    e.cyc  = at;
    return e;
  endfunction

  // Monitor: pops expectations on each flags_valid pulse, otherwise checks hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_pulse: expected at cycle %0d, now %0d", exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (flags_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse at cycle %0d diff=0x%0h", cyc, diff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
          chk("diff", 64'(diff), 64'(e.diff));
          chk("flags_zsvc", {60'd0, zf, sf, vf, cf}, {60'd0, e.zf, e.sf, e.vf, e.cf});
          last_out = {e.diff, e.zf, e.sf, e.vf, e.cf};
        end
      end else begin
        chk("flags_valid_low", {63'd0, flags_valid}, 64'd0);
        chk("hold", {28'd0, diff, zf, sf, vf, cf}, {28'd0, last_out});
      end
    end
  end

  // Issue one compare; returns in the DONE cycle with start low.
  // While CALC runs, start and operands are scrambled; they must be ignored.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    exp_q.push_back(model(a, b, cyc + 5));
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("busy_calc", {63'd0, busy}, 64'd1);
      start = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      op_a  = $urandom;
      op_b  = $urandom;
      @(posedge clk); #1;
    end
    chk("busy_done", {63'd0, busy}, 64'd0);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;  // reset must win over start
    op_a  = 32'd9;
    op_b  = 32'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valid", {63'd0, flags_valid}, 64'd0);
    chk("rst_outs", {28'd0, diff, zf, sf, vf, cf}, 64'd0);
    start    = 1'b0;
    rst_n    = 1'b1;
    last_out = '0;
    mon_en   = 1'b1;
    idle(1);

    // Directed corner cases.
    issue(32'd5, 32'd5);               idle(1);
    issue(32'd1, 32'd2);               idle(2);
    issue(32'h8000_0000, 32'd1);       idle(1);
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    issue(32'd3, 32'd7);               // back-to-back from DONE
    idle(2);

    // Reset during the third CALC cycle abandons the compare.
    start = 1'b1;
    op_a  = 32'h1234_5678;
    op_b  = 32'h0000_0001;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_valid", {63'd0, flags_valid}, 64'd0);
    chk("midrst_outs", {28'd0, diff, zf, sf, vf, cf}, 64'd0);
    exp_q.delete();
    last_out = '0;
    rst_n    = 1'b1;
    start    = 1'b0;
    idle(6);  // no pulse may appear for the abandoned compare
    issue(32'd100, 32'd42);
    idle(1);

    // Randomized traffic, mixing back-to-back and gapped requests.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: a = {1'b1, a[30:0]};
        default: ;
      endcase
      issue(a, b);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(8);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
